// File: rtl/sap1_loader_if.sv
// Byte-stream, front-panel and status signals between the SAP-1 program loader
// and its surroundings (byte source, SAP-1 front panel, host).
`timescale 1ns/1ps
interface sap1_loader_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  load_start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic [7:0]            rd_data;
  logic                  fp_clear;
  logic                  fp_prog;
  logic                  fp_write;
  logic [ADDR_WIDTH-1:0] fp_adr;
  logic [7:0]            fp_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output load_start, in_valid, in_data, rd_data,
    input  in_ready, fp_clear, fp_prog, fp_write, fp_adr, fp_data,
           busy, done, err
  );

  modport slave (
    input  load_start, in_valid, in_data, rd_data,
    output in_ready, fp_clear, fp_prog, fp_write, fp_adr, fp_data,
           busy, done, err
  );
endinterface

// File: rtl/sap1_loader.sv
// Streams 2**ADDR_WIDTH bytes into SAP-1 program memory through the front panel,
// verifies each write by readback and checks a trailing mod-256 checksum byte.
`timescale 1ns/1ps
module sap1_loader #(
  parameter int ADDR_WIDTH = 4
) (
  input logic         sysclk,
  input logic         reset_n,
  sap1_loader_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_WAIT, S_SETUP, S_WRITE,
    S_HOLD, S_CHECK, S_SUM, S_RELEASE, S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_loaded;
  logic                  w_loaded_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [7:0]            r_byte;
  logic [7:0]            r_sum;
  logic                  r_in_ready, r_fp_clear, r_fp_prog, r_fp_write;
  logic                  r_busy, r_done, r_err;
  logic                  w_in_ready, w_fp_clear, w_fp_prog, w_fp_write;
  logic                  w_busy, w_done, w_err;
  logic                  w_xfer;

  assign w_xfer = bus.in_valid & r_in_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_loaded_nxt = r_loaded;
    case (r_state)
      S_IDLE:    if (bus.load_start) w_state_nxt = S_CLEAR;
      S_CLEAR:   w_state_nxt = S_WAIT;
      S_WAIT:    if (w_xfer) w_state_nxt = S_SETUP;
      S_SETUP:   w_state_nxt = S_WRITE;
      S_WRITE:   w_state_nxt = S_HOLD;
      S_HOLD:    w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (bus.rd_data != r_byte)  w_state_nxt = S_ERROR;
        else if (r_cnt == LAST_ADR) w_state_nxt = S_SUM;
        else                        w_state_nxt = S_WAIT;
      end
      S_SUM:     if (w_xfer) w_state_nxt = (bus.in_data == r_sum) ? S_RELEASE : S_ERROR;
      S_RELEASE: w_state_nxt = S_IDLE;
      S_ERROR:   if (bus.load_start) w_state_nxt = S_CLEAR;
      default:   w_state_nxt = S_IDLE;
    endcase

    if (r_state == S_RELEASE)   w_loaded_nxt = 1'b1;
    if (w_state_nxt == S_ERROR) w_loaded_nxt = 1'b0;

    // Outputs are decoded from the next state so the registered copy tracks r_state.
    w_in_ready = (w_state_nxt == S_WAIT) || (w_state_nxt == S_SUM);
    w_fp_write = (w_state_nxt == S_WRITE);
    w_fp_prog  = w_state_nxt inside {S_CLEAR, S_WAIT, S_SETUP, S_WRITE, S_HOLD, S_CHECK, S_SUM};
    w_busy     = w_fp_prog || (w_state_nxt == S_RELEASE);
    w_fp_clear = (w_state_nxt == S_IDLE) ? ~w_loaded_nxt : 1'b1;
    w_done     = (w_state_nxt == S_RELEASE);
    w_err      = (w_state_nxt == S_ERROR);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_loaded   <= 1'b0;
      r_in_ready <= 1'b0;
      r_fp_clear <= 1'b1;
      r_fp_prog  <= 1'b0;
      r_fp_write <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_loaded   <= w_loaded_nxt;
      r_in_ready <= w_in_ready;
      r_fp_clear <= w_fp_clear;
      r_fp_prog  <= w_fp_prog;
      r_fp_write <= w_fp_write;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_adr  <= '0;
      r_byte <= '0;
      r_sum  <= '0;
    end else if (r_state == S_CLEAR) begin
      r_cnt  <= '0;
      r_adr  <= '0;
      r_byte <= '0;
      r_sum  <= '0;
    end else if (r_state == S_WAIT && w_xfer) begin
      r_byte <= bus.in_data;
      r_sum  <= r_sum + bus.in_data;
      r_adr  <= r_cnt;
    end else if (r_state == S_CHECK && w_state_nxt == S_WAIT) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.fp_clear = r_fp_clear;
  assign bus.fp_prog  = r_fp_prog;
  assign bus.fp_write = r_fp_write;
  assign bus.fp_adr   = r_adr;
  assign bus.fp_data  = r_byte;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_sap1_loader.sv
// Scoreboard bench for sap1_loader: stimulus queues expected front-panel writes and
// done/err events, a negedge monitor pops and compares them; directed checks cover the rest.
`timescale 1ns/1ps
module tb_sap1_loader;
  typedef struct {
    int         kind;   // 0 write, 1 done, 2 err
    logic [3:0] adr;
    logic [7:0] data;
  } ev_t;

  logic sysclk = 1'b0;
  logic reset_n = 1'b0;
  logic fault_en = 1'b0;
  logic fill = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] mem [16];
  ev_t  exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   ne_idx = 0;
  int   last_xfer = 0;
  bit   lat_pend = 1'b0;

  always #5 sysclk = ~sysclk;

  sap1_loader_if #(.ADDR_WIDTH(4)) bus ();

  sap1_loader #(.ADDR_WIDTH(4)) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // SAP-1 program memory model with an optional stuck readback at address 5.
  always @(posedge sysclk) begin
    if (fill) begin
      for (int k = 0; k < 16; k++) mem[k] <= 8'hEE;
    end else if (bus.fp_write) begin
      mem[bus.fp_adr] <= bus.fp_data;
    end
  end
  assign bus.rd_data = (fault_en && bus.fp_adr == 4'd5) ? 8'hFF : mem[bus.fp_adr];

  function automatic ev_t mk(input int k, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.adr  = a;
    e.data = d;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int k, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d adr=%0d data=%h, expected nothing (t=%0t)",
               k, a, d, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.adr !== a || e.data !== d) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d adr=%0d data=%h, expected kind=%0d adr=%0d data=%h (t=%0t)",
                 k, a, d, e.kind, e.adr, e.data, $time);
      end
    end
  endtask

  // Monitor: scoreboard events plus the accept-to-next-ready spacing of 5 negedges.
  always @(negedge sysclk) begin
    ne_idx++;
    if (reset_n) begin
      if (bus.fp_write) sb_pop(0, bus.fp_adr, bus.fp_data);
      if (bus.done) sb_pop(1, 4'd0, 8'd0);
      if (bus.err && !prev_err) sb_pop(2, 4'd0, 8'd0);
    end
    prev_err = bus.err;
    if (!reset_n || !bus.busy) begin
      lat_pend = 1'b0;
    end else if (bus.in_ready) begin
      if (lat_pend) chk("byte_latency", ne_idx - last_xfer, 5);
      lat_pend = 1'b0;
    end
    if (reset_n && bus.busy && bus.in_valid && bus.in_ready) begin
      lat_pend  = 1'b1;
      last_xfer = ne_idx;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    bit taken = 1'b0;
    int n = 0;
    while (!taken && n < 200) begin
      @(posedge sysclk); #1;
      bus.in_data  = b;
      bus.in_valid = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
      taken = bus.in_valid && bus.in_ready;
      n++;
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted, expected acceptance within 200 cycles", b);
    end
  endtask

  task automatic pulse_start();
    @(posedge sysclk); #1;
    bus.load_start = 1'b1;
    @(posedge sysclk); #1;
    bus.load_start = 1'b0;
  endtask

  task automatic do_fill();
    @(posedge sysclk); #1;
    fill = 1'b1;
    @(posedge sysclk); #1;
    fill = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge sysclk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_vector(input string name);
    chk(name, {bus.in_ready, bus.fp_clear, bus.fp_prog, bus.fp_write, bus.fp_adr,
                bus.fp_data, bus.busy, bus.done, bus.err},
        {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0});
  endtask

  // Full 16-byte load of data i at address i; kick_at >= 0 pulses load_start mid-load.
  task automatic run_load(input logic [7:0] csum, input bit throttle, input int kick_at);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(i);
      exp_q.push_back(mk(0, 4'(i), b));
      send_byte(b, throttle);
      if (i == kick_at) begin
        @(posedge sysclk); #1;
        bus.load_start = 1'b1;
        chk("busy_at_kick", bus.busy, 1);
        @(posedge sysclk); #1;
        bus.load_start = 1'b0;
      end
    end
    exp_q.push_back(mk((csum == 8'h78) ? 1 : 2, 4'd0, 8'd0));
    send_byte(csum, throttle);
    @(posedge sysclk); #1;
    bus.in_valid = 1'b0;
    while (!bus.done && !bus.err && n < 20) begin
      @(posedge sysclk); #1;
      n++;
    end
    if (csum == 8'h78) begin
      chk("release_flags", {bus.done, bus.err, bus.fp_clear, bus.fp_prog, bus.busy}, 5'b10101);
      @(posedge sysclk); #1;
      chk("idle_after_release", {bus.done, bus.fp_clear, bus.fp_prog, bus.busy}, 4'b0000);
      for (int i = 0; i < 16; i++) chk("mem_image", mem[i], i);
    end else begin
      chk("error_flags", {bus.done, bus.err, bus.fp_clear, bus.fp_prog, bus.busy}, 5'b01100);
    end
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    repeat (3) @(posedge sysclk);
    #1;
    check_reset_vector("reset_state");
    reset_n = 1'b1;
    do_fill();

    // Clean load, in_valid held high throughout.
    pulse_start();
    chk("clear_state", {bus.fp_clear, bus.fp_prog, bus.busy, bus.err, bus.in_ready}, 5'b11100);
    run_load(8'h78, 1'b0, -1);
    settle();

    // Bad checksum, then restart clears err in CLEAR.
    do_fill();
    pulse_start();
    run_load(8'h79, 1'b0, -1);
    settle();
    chk("err_sticky", {bus.err, bus.fp_clear, bus.fp_prog, bus.in_ready}, 4'b1100);
    fault_en = 1'b1;
    pulse_start();
    chk("err_cleared_in_clear", {bus.err, bus.busy, bus.fp_prog}, 3'b011);

    // Readback fault at address 5: error after its CHECK, no further writes.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mk(0, 4'(i), 8'(i)));
      send_byte(8'(i), 1'b0);
    end
    exp_q.push_back(mk(2, 4'd0, 8'd0));
    @(posedge sysclk); #1;
    bus.in_data = 8'h06;
    repeat (15) @(posedge sysclk);
    #1;
    bus.in_valid = 1'b0;
    chk("readback_error", {bus.err, bus.busy, bus.fp_prog, bus.fp_write, bus.fp_clear}, 5'b10001);
    chk("readback_adr", bus.fp_adr, 5);
    settle();
    fault_en = 1'b0;

    // Throttled source with an ignored load_start mid-load.
    do_fill();
    pulse_start();
    run_load(8'h78, 1'b1, 7);
    settle();

    // Reset during the WRITE of address 9, then a full load.
    do_fill();
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(mk(0, 4'(i), 8'(i)));
      send_byte(8'(i), 1'b0);
    end
    send_byte(8'h09, 1'b0);
    @(posedge sysclk); #1;
    bus.in_valid = 1'b0;
    @(posedge sysclk); #1;
    chk("write9_active", {bus.fp_write, bus.fp_adr}, {1'b1, 4'd9});
    reset_n = 1'b0;
    #1;
    check_reset_vector("reset_in_write");
    repeat (2) @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    @(posedge sysclk); #1;
    chk("mem9_untouched", mem[9], 8'hEE);
    chk("clear_after_reset", {bus.fp_clear, bus.busy, bus.err, bus.done}, 4'b1000);
    settle();
    pulse_start();
    run_load(8'h78, 1'b0, -1);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sap1_loader.md
SAP1_LOADER -- requirements
Module: sap1_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, program-memory address width; word count N = 2**ADDR_WIDTH (16).
REQ-002 sysclk  in  1  single clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 load_start  in  1  one-cycle request to begin a load; honoured only in IDLE or ERROR.
REQ-005 in_valid / in_data  in  1 / 8  byte-stream source; a byte transfers when in_valid and in_ready are both 1 on an edge.
REQ-006 in_ready  out  1  loader accepts a byte this cycle.
REQ-007 rd_data  in  8  memory readback (sap1 bus w_bus while fp_prog=1).
REQ-008 fp_clear, fp_prog, fp_write  out  1 each  front-panel controls into sap1.
REQ-009 fp_adr / fp_data  out  ADDR_WIDTH / 8  front-panel address and write data.
REQ-010 busy, done, err  out  1 each  load in progress; one-cycle success pulse; sticky failure flag.

Function
REQ-011 States: IDLE, CLEAR, WAIT, SETUP, WRITE, HOLD, CHECK, SUM, RELEASE, ERROR; all outputs registered.
REQ-012 IDLE: in_ready=0, fp_prog=0, fp_write=0, fp_clear = NOT loaded (loaded is an internal flag); load_start -> CLEAR.
REQ-013 CLEAR: one cycle, fp_clear=1, fp_prog=1, address counter and checksum cleared to 0, err cleared -> WAIT.
REQ-014 fp_clear=1 and fp_prog=1 in every state from CLEAR through SUM; busy=1 in those states and RELEASE.
REQ-015 WAIT: in_ready=1; on transfer latch in_data into byte register, add it into 8-bit checksum (mod 256) -> SETUP; in_ready=0 in all other states.
REQ-016 SETUP: fp_adr=counter, fp_data=byte, fp_write=0 -> WRITE; WRITE: fp_write=1 exactly one cycle -> HOLD; HOLD: fp_write=0 -> CHECK; fp_adr/fp_data stable from SETUP through CHECK.
REQ-017 CHECK: compare rd_data with byte; mismatch -> ERROR; match and counter=N-1 -> SUM; match otherwise -> counter+1, WAIT.
REQ-018 Per-byte latency from accepted transfer to next in_ready=1: exactly 4 cycles (SETUP, WRITE, HOLD, CHECK).
REQ-019 SUM: in_ready=1; on transfer compare in_data with checksum; equal -> RELEASE; unequal -> ERROR; received byte not written to memory.
REQ-020 RELEASE: one cycle, fp_prog=0, fp_clear=1, done=1, loaded set -> IDLE (fp_clear=0 from next cycle).
REQ-021 ERROR: fp_clear=1, fp_prog=0, fp_write=0, err=1, loaded cleared; held until load_start (-> CLEAR) or reset.
REQ-022 load_start during any busy state is ignored; in_valid while in_ready=0 is ignored (byte not consumed).
REQ-023 Address counter never wraps within a load; 17th data byte is always treated as checksum.
REQ-024 fp_write is never 1 outside WRITE; fp_adr/fp_data change only in CLEAR and WAIT-transfer cycles.

Reset
REQ-025 reset_n=0 asynchronously forces IDLE, loaded=0, counter=0, checksum=0, fp_adr=0, fp_data=0, fp_write=0, fp_prog=0, fp_clear=1, in_ready=0, busy=0, done=0, err=0.
REQ-026 Reset mid-load (including during WRITE) drops fp_write the same instant; partially written memory is not cleaned; after release fp_clear stays 1 until a successful load.

Verification
REQ-027 Clean load: bytes 0x00..0x0F then checksum 0x78, in_valid always 1 -> 16 single-cycle fp_write pulses at fp_adr 0..15, done pulse, fp_clear falls cycle after RELEASE.
REQ-028 Bad checksum: same data, checksum 0x79 -> no done, err=1, fp_clear=1, fp_prog=0; then load_start -> err cleared in CLEAR.
REQ-029 Readback fault: model forces rd_data=0xFF at address 5 while written 0x05 -> ERROR entered from CHECK of address 5, no further writes.
REQ-030 Throttled source: in_valid gated randomly, load_start pulsed mid-load -> identical memory image and done as REQ-027, load_start ignored.
REQ-031 Reset asserted in WRITE of address 9 -> fp_write=0 immediately, fp_clear=1, all flags 0; subsequent full load succeeds.
